// File: rtl/fht_pkg.sv
// Shared defaults, pipeline latency and the saturation helper for the FHT butterfly.
package fht_pkg;

  localparam int unsigned D_BIT_DEF   = 32'd16;
  localparam int unsigned W_BIT_DEF   = 32'd12;
  localparam int unsigned CNT_BIT_DEF = 32'd16;
  localparam int unsigned BUT_LAT     = 32'd3;

  // Clamp a wide signed value into the signed range of a dbit-wide word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned dbit);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dbit - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (dbit - 32'd1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fht_rot_mul.sv
// Twiddle rotation: registers both products, then the rounded Q1.(W_BIT-1) sum T.
module fht_rot_mul
  import fht_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int W_BIT = W_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [D_BIT-1:0]   x_1,
  input  logic signed [D_BIT-1:0]   x_2,
  input  logic signed [W_BIT-1:0]   coef_sin,
  input  logic signed [W_BIT-1:0]   coef_cos,
  output logic signed [D_BIT+1:0]   t
);

  localparam int P  = D_BIT + W_BIT;
  localparam int PS = P + 1;
  localparam int TW = D_BIT + 2;
  localparam logic signed [P:0] RND_HALF = {{(P - W_BIT + 2){1'b0}}, 1'b1, {(W_BIT - 2){1'b0}}};

  logic signed [P-1:0]  prod_c_r;
  logic signed [P-1:0]  prod_s_r;
  logic signed [TW-1:0] t_r;
  logic signed [P:0]    sum_s;
  logic signed [P:0]    rnd_s;

  // Exact product sum plus half an LSB of the coefficient scale.
  always_comb begin
    sum_s = PS'(prod_c_r) + PS'(prod_s_r);
    rnd_s = sum_s + RND_HALF;
  end

  // S1 products and S2 rounded T, both frozen while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_c_r <= '0;
      prod_s_r <= '0;
      t_r      <= '0;
    end else if (en) begin
      prod_c_r <= P'(coef_cos) * P'(x_1);
      prod_s_r <= P'(coef_sin) * P'(x_2);
      t_r      <= TW'(rnd_s >>> (W_BIT - 1));
    end
  end

  assign t = t_r;

endmodule

// File: rtl/fht_but_pipe.sv
// Three-stage radix-2 FHT butterfly with valid/ready flow control,
// optional halving, output saturation and a saturating overflow counter.
module fht_but_pipe
  import fht_pkg::*;
#(
  parameter int D_BIT   = D_BIT_DEF,
  parameter int W_BIT   = W_BIT_DEF,
  parameter int CNT_BIT = CNT_BIT_DEF
) (
  input  logic                     iCLK,
  input  logic                     iRESET,
  input  logic                     iVALID,
  output logic                     oREADY,
  input  logic signed [D_BIT-1:0]  iX_0,
  input  logic signed [D_BIT-1:0]  iX_1,
  input  logic signed [D_BIT-1:0]  iX_2,
  input  logic signed [W_BIT-1:0]  iSIN,
  input  logic signed [W_BIT-1:0]  iCOS,
  input  logic                     iSCALE,
  output logic                     oVALID,
  input  logic                     iREADY,
  output logic signed [D_BIT-1:0]  oY_0,
  output logic signed [D_BIT-1:0]  oY_1,
  output logic                     oOVF,
  input  logic                     iCLR_CNT,
  output logic [CNT_BIT-1:0]       oOVF_CNT
);

  localparam logic [CNT_BIT-1:0] CNT_MAX = {CNT_BIT{1'b1}};
  localparam logic [CNT_BIT-1:0] CNT_ONE = {{(CNT_BIT-1){1'b0}}, 1'b1};

  logic                      en_s;
  logic                      v1_r, v2_r, v3_r;
  logic                      sc_1_r, sc_2_r;
  logic signed [D_BIT-1:0]   x0_1_r, x0_2_r;
  logic signed [D_BIT-1:0]   y0_r, y1_r;
  logic                      ovf_r;
  logic [CNT_BIT-1:0]        cnt_r;
  logic signed [D_BIT+1:0]   t_s;
  logic signed [63:0]        sum0_s, sum1_s, sh0_s, sh1_s, sat0_s, sat1_s;
  logic                      ovf_s;

  // Everything advances unless a valid output is being held back.
  assign en_s   = !(v3_r && !iREADY);
  assign oREADY = en_s;

  fht_rot_mul #(
    .D_BIT (D_BIT),
    .W_BIT (W_BIT)
  ) u_rot (
    .clk      (iCLK),
    .rst      (iRESET),
    .en       (en_s),
    .x_1      (iX_1),
    .x_2      (iX_2),
    .coef_sin (iSIN),
    .coef_cos (iCOS),
    .t        (t_s)
  );

  // Butterfly sums at full width, optional floor halving, then clamping.
  always_comb begin
    sum0_s = 64'(x0_2_r) + 64'(t_s);
    sum1_s = 64'(x0_2_r) - 64'(t_s);
    sh0_s  = sc_2_r ? (sum0_s >>> 1'b1) : sum0_s;
    sh1_s  = sc_2_r ? (sum1_s >>> 1'b1) : sum1_s;
    sat0_s = saturate(sh0_s, D_BIT);
    sat1_s = saturate(sh1_s, D_BIT);
    ovf_s  = (sat0_s != sh0_s) || (sat1_s != sh1_s);
  end

  // Valid bits and side-band data; output word only refreshes on a valid S2.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      v3_r   <= 1'b0;
      sc_1_r <= 1'b0;
      sc_2_r <= 1'b0;
      x0_1_r <= '0;
      x0_2_r <= '0;
      y0_r   <= '0;
      y1_r   <= '0;
      ovf_r  <= 1'b0;
    end else if (en_s) begin
      v1_r   <= iVALID;
      sc_1_r <= iSCALE;
      x0_1_r <= iX_0;
      v2_r   <= v1_r;
      sc_2_r <= sc_1_r;
      x0_2_r <= x0_1_r;
      v3_r   <= v2_r;
      if (v2_r) begin
        y0_r  <= D_BIT'(sat0_s);
        y1_r  <= D_BIT'(sat1_s);
        ovf_r <= ovf_s;
      end
    end
  end

  // Overflow event counter; clear beats a simultaneous count.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      cnt_r <= '0;
    end else if (iCLR_CNT) begin
      cnt_r <= '0;
    end else if (v3_r && iREADY && ovf_r && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign oVALID   = v3_r;
  assign oY_0     = y0_r;
  assign oY_1     = y1_r;
  assign oOVF     = ovf_r;
  assign oOVF_CNT = cnt_r;

endmodule

// File: tb/tb_fht_but_pipe.sv
// Self-checking bench: transaction-level reference model plus directed pins.
module tb_fht_but_pipe;

  localparam int D = 16;
  localparam int W = 12;
  localparam int C = 4;

  logic                  clk = 1'b0;
  logic                  iRESET, iVALID, iREADY, iSCALE, iCLR_CNT;
  logic signed [D-1:0]   iX_0, iX_1, iX_2;
  logic signed [W-1:0]   iSIN, iCOS;
  logic                  oREADY, oVALID, oOVF;
  logic signed [D-1:0]   oY_0, oY_1;
  logic [C-1:0]          oOVF_CNT;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_del  = 0;
  bit chk_on = 1'b0;

  fht_but_pipe #(.D_BIT(D), .W_BIT(W), .CNT_BIT(C)) dut (
    .iCLK(clk), .iRESET(iRESET), .iVALID(iVALID), .oREADY(oREADY),
    .iX_0(iX_0), .iX_1(iX_1), .iX_2(iX_2), .iSIN(iSIN), .iCOS(iCOS),
    .iSCALE(iSCALE), .oVALID(oVALID), .iREADY(iREADY),
    .oY_0(oY_0), .oY_1(oY_1), .oOVF(oOVF),
    .iCLR_CNT(iCLR_CNT), .oOVF_CNT(oOVF_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference butterfly straight from the arithmetic definition.
  function automatic void calc(input longint x0, input longint x1, input longint x2,
                               input longint c, input longint s, input bit sc,
                               output longint y0, output longint y1, output bit ovf,
                               output real r0, output real r1);
    longint t, a, b, hi, lo;
    real tr;
    hi = (longint'(1) <<< (D - 1)) - 1;
    lo = -hi - 1;
    t  = (c * x1 + s * x2 + (longint'(1) <<< (W - 2))) >>> (W - 1);
    a  = x0 + t;
    b  = x0 - t;
    if (sc) begin
      a = a >>> 1;
      b = b >>> 1;
    end
    ovf = (a > hi) || (a < lo) || (b > hi) || (b < lo);
    y0  = (a > hi) ? hi : ((a < lo) ? lo : a);
    y1  = (b > hi) ? hi : ((b < lo) ? lo : b);
    tr  = real'(c * x1 + s * x2) / real'(longint'(1) <<< (W - 1));
    r0  = real'(x0) + tr;
    r1  = real'(x0) - tr;
    if (sc) begin
      r0 = r0 / 2.0;
      r1 = r1 / 2.0;
    end
    if (r0 > real'(hi)) r0 = real'(hi);
    if (r0 < real'(lo)) r0 = real'(lo);
    if (r1 > real'(hi)) r1 = real'(hi);
    if (r1 < real'(lo)) r1 = real'(lo);
  endfunction

  // Model: results computed at acceptance, carried through a 3-deep delay line.
  bit     m_v[2];
  longint m_y0[2], m_y1[2];
  bit     m_f[2];
  real    m_r0[2], m_r1[2];
  bit     m_ovalid = 1'b0, m_oovf = 1'b0;
  longint m_oy0 = 0, m_oy1 = 0;
  real    m_or0 = 0.0, m_or1 = 0.0;
  int     m_cnt = 0;

  always @(posedge clk) begin
    bit en;
    if (iRESET) begin
      m_v[0] = 1'b0; m_v[1] = 1'b0;
      m_ovalid = 1'b0; m_oovf = 1'b0; m_oy0 = 0; m_oy1 = 0; m_cnt = 0;
    end else begin
      en = !(m_ovalid && !iREADY);
      if (iCLR_CNT) m_cnt = 0;
      else if (m_ovalid && iREADY && m_oovf && m_cnt < (1 << C) - 1) m_cnt = m_cnt + 1;
      if (en) begin
        m_ovalid = m_v[1];
        if (m_v[1]) begin
          m_oy0 = m_y0[1]; m_oy1 = m_y1[1]; m_oovf = m_f[1];
          m_or0 = m_r0[1]; m_or1 = m_r1[1];
        end
        m_v[1] = m_v[0]; m_y0[1] = m_y0[0]; m_y1[1] = m_y1[0];
        m_f[1] = m_f[0]; m_r0[1] = m_r0[0]; m_r1[1] = m_r1[0];
        m_v[0] = iVALID;
        if (iVALID)
          calc($signed(iX_0), $signed(iX_1), $signed(iX_2), $signed(iCOS), $signed(iSIN),
               iSCALE, m_y0[0], m_y1[0], m_f[0], m_r0[0], m_r1[0]);
      end
    end
  end

  // Single compare point, half a cycle away from the active edge.
  always @(negedge clk) begin
    real e0, e1;
    if (chk_on) begin
      chk("ovalid", oVALID, m_ovalid);
      chk("oready", oREADY, !(m_ovalid && !iREADY));
      chk("y0", $signed(oY_0), m_oy0);
      chk("y1", $signed(oY_1), m_oy1);
      chk("ovf", oOVF, m_oovf);
      chk("ovf_cnt", oOVF_CNT, m_cnt);
      if (oVALID) begin
        e0 = real'($signed(oY_0)) - m_or0;
        e1 = real'($signed(oY_1)) - m_or1;
        chk("real_err_y0", (e0 <= 1.0 && e0 >= -1.0), 1);
        chk("real_err_y1", (e1 <= 1.0 && e1 >= -1.0), 1);
      end
      if (iVALID && oREADY) n_acc++;
      if (oVALID && iREADY) n_del++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send1(input int x0, input int x1, input int x2, input int c, input int s, input bit sc);
    iVALID = 1'b1;
    iX_0 = D'(x0); iX_1 = D'(x1); iX_2 = D'(x2);
    iCOS = W'(c); iSIN = W'(s); iSCALE = sc;
    step();
    iVALID = 1'b0;
  endtask

  longint py0, py1;
  bit     pf;
  real    pr0, pr1;
  longint q[$];

  initial begin
    iRESET = 1'b1; iVALID = 1'b0; iREADY = 1'b1; iSCALE = 1'b0; iCLR_CNT = 1'b0;
    iX_0 = '0; iX_1 = '0; iX_2 = '0; iSIN = '0; iCOS = '0;
    step();
    chk_on = 1'b1;
    step();
    iRESET = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", oVALID, 0);
    chk("rst_oready", oREADY, 1);
    chk("rst_cnt", oOVF_CNT, 0);
    chk("rst_y0", $signed(oY_0), 0);

    calc(100, 400, 0, 1024, 0, 1'b1, py0, py1, pf, pr0, pr1);
    chk("model_sc_y0", py0, 150);
    chk("model_sc_y1", py1, -50);
    calc(32767, 32767, 0, 2047, 0, 1'b0, py0, py1, pf, pr0, pr1);
    chk("model_sat_y1", py1, 16);
    chk("model_sat_ovf", pf, 1);

    step();
    send1(100, 400, 0, 1024, 0, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("scale_on_valid", oVALID, 1);
    chk("scale_on_y0", $signed(oY_0), 150);
    chk("scale_on_y1", $signed(oY_1), -50);
    chk("scale_on_ovf", oOVF, 0);

    step();
    send1(100, 400, 0, 1024, 0, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("scale_off_y0", $signed(oY_0), 300);
    chk("scale_off_y1", $signed(oY_1), -100);

    step();
    send1(32767, 32767, 0, 2047, 0, 1'b0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("sat_y0", $signed(oY_0), 32767);
    chk("sat_y1", $signed(oY_1), 16);
    chk("sat_ovf", oOVF, 1);
    chk("sat_cnt_before", oOVF_CNT, 0);
    @(negedge clk);
    chk("sat_cnt_after", oOVF_CNT, 1);

    step();
    send1(32767, 32767, 0, 2047, 0, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 iCLR_CNT = 1'b1;
    @(posedge clk);
    #2 iCLR_CNT = 1'b0;
    @(negedge clk);
    chk("clr_wins", oOVF_CNT, 0);

    // Three back-to-back samples, then downstream stalls for four cycles.
    step();
    iVALID = 1'b1; iX_1 = '0; iX_2 = '0; iCOS = '0; iSIN = '0; iSCALE = 1'b0;
    iX_0 = D'(10); step();
    iX_0 = D'(20); step();
    iX_0 = D'(30); step();
    iVALID = 1'b0; iREADY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_oready", oREADY, 0);
      chk("stall_y0", $signed(oY_0), 10);
      step();
    end
    iREADY = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (oVALID) q.push_back($signed(oY_0));
    end
    chk("stall_count", q.size(), 3);
    for (int i = 0; i < 3; i++) chk("stall_order", (q.size() > i) ? q[i] : -1, 10 * (i + 1));

    // Reset with two samples in flight, then a fresh sample.
    step();
    iVALID = 1'b1; iX_0 = D'(5); step();
    iX_0 = D'(6); step();
    iVALID = 1'b0; iRESET = 1'b1;
    step();
    iRESET = 1'b0; iVALID = 1'b1; iX_0 = D'(7);
    @(negedge clk);
    chk("midrst_ovalid", oVALID, 0);
    chk("midrst_cnt", oOVF_CNT, 0);
    chk("midrst_oready", oREADY, 1);
    step();
    iVALID = 1'b0;
    @(negedge clk); chk("post_rst_lat1", oVALID, 0);
    @(negedge clk); chk("post_rst_lat2", oVALID, 0);
    @(negedge clk); chk("post_rst_lat3", oVALID, 1);
    chk("post_rst_y0", $signed(oY_0), 7);

    step(); step();
    n_acc = 0; n_del = 0;
    for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
      iVALID   = ($urandom_range(99) < 75);
      iREADY   = ($urandom_range(99) < 80);
      iSCALE   = $urandom_range(1);
      iCLR_CNT = ($urandom_range(63) == 0);
      iX_0 = ($urandom_range(7) == 0) ? D'(32767) : D'($urandom);
      iX_1 = ($urandom_range(7) == 0) ? D'(-32768) : D'($urandom);
      iX_2 = D'($urandom);
      iCOS = ($urandom_range(7) == 0) ? W'(-2048) : W'($urandom);
      iSIN = ($urandom_range(7) == 0) ? W'(2047) : W'($urandom);
      step();
    end
    chk("rand_samples", n_acc >= 10000, 1);
    iVALID = 1'b0; iREADY = 1'b1; iCLR_CNT = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("no_loss_dup", n_del, n_acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
